threat_countdown: RTL and testbench

Parametrised successor of the fixed 3-input self-destruct counter. It runs N_IN debounced threat channels through a K-of-N vote, then a seconds countdown to LIMIT that latches a sticky `fired` state and drives an LED display. It sits directly behind the top-level switch inputs and replaces the separate debouncer, vote, counter and display stages with one tick-enabled, single-clock block.

---
 rtl/threat_countdown.sv | 148 ++++++++++++++
 tb/tb_threat_countdown.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/threat_countdown.sv
// threat_countdown: debounced K-of-N threat vote feeding a seconds countdown
// that latches a sticky fired state and drives an LED display. Single clock,
// all sequential state advances on posedge clk; debounce and counting are
// gated by the one-cycle tick enable.
module threat_countdown #(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned K             = 2,
  parameter int unsigned DEB_TICKS     = 3,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned LIMIT         = 10,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned HOLD_MODE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             arm_i,
  input  logic [N_IN-1:0]  threat_i,
  output logic [CNT_W-1:0] count_o,
  output logic             fired_o,
  output logic [CNT_W-1:0] leds_o,
  output logic [1:0]       state_o
);

  localparam int unsigned RUN_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;
  localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned PC_W  = $clog2(N_IN + 1);
  localparam int unsigned NCH   = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    FIRED    = 2'd3
  } state_e;

  // Channel N_IN is the arm switch; lower channels are the threat switches.
  logic [NCH-1:0]   raw_c;
  logic [NCH-1:0]   deb_q;
  logic [RUN_W-1:0] run_q [NCH];
  logic [PC_W-1:0]  pop_c;
  logic             vote_d;
  logic             vote_q;
  logic             arm_deb_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             sub_wrap_c;

  state_e           state_q;
  logic [SUB_W-1:0] sub_q;
  logic [CNT_W-1:0] count_q;
  logic             fired_q;
  logic [CNT_W-1:0] leds_q;

  assign raw_c     = {arm_i, threat_i};
  assign arm_deb_c = deb_q[N_IN];

  // Per-channel debounce: flip after DEB_TICKS consecutive disagreeing ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) run_q[i] <= '0;
    end else if (tick_i) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (raw_c[i] != deb_q[i]) begin
          if (run_q[i] == RUN_W'(DEB_TICKS - 1)) begin
            deb_q[i] <= ~deb_q[i];
            run_q[i] <= '0;
          end else begin
            run_q[i] <= run_q[i] + RUN_W'(1);
          end
        end else begin
          run_q[i] <= '0;
        end
      end
    end
  end

  // Popcount of debounced threats compared against the vote threshold.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < N_IN; i++) pop_c = pop_c + PC_W'(deb_q[i]);
    vote_d = (pop_c >= PC_W'(K));
  end

  // Registered vote, one clk behind the debounced values.
  always_ff @(posedge clk) begin
    if (rst) vote_q <= 1'b0;
    else     vote_q <= vote_d;
  end

  assign cnt_inc_c  = count_q + CNT_W'(1);
  assign sub_wrap_c = (sub_q == SUB_W'(TICKS_PER_SEC - 1));

  // Countdown FSM; arm loss takes priority over every state, FIRED is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sub_q   <= '0;
      count_q <= '0;
      fired_q <= 1'b0;
    end else if (!arm_deb_c) begin
      state_q <= IDLE;
      sub_q   <= '0;
      count_q <= '0;
      fired_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:  state_q <= ARMED;
        ARMED: if (vote_q) state_q <= COUNTING;
        COUNTING: begin
          if (!vote_q) begin
            // Vote loss beats a coincident tick, including at second wrap.
            state_q <= ARMED;
            if (HOLD_MODE == 0) begin
              sub_q   <= '0;
              count_q <= '0;
            end
          end else if (tick_i) begin
            if (sub_wrap_c) begin
              sub_q   <= '0;
              count_q <= cnt_inc_c;
              if (cnt_inc_c == CNT_W'(LIMIT)) begin
                fired_q <= 1'b1;
                state_q <= FIRED;
              end
            end else begin
              sub_q <= sub_q + SUB_W'(1);
            end
          end
        end
        FIRED:   fired_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Display register lags count/fired by one clk.
  always_ff @(posedge clk) begin
    if (rst) leds_q <= '0;
    else     leds_q <= fired_q ? {CNT_W{1'b1}} : count_q;
  end

  assign count_o = count_q;
  assign fired_o = fired_q;
  assign leds_o  = leds_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_threat_countdown.sv
// Directed bench for threat_countdown. Three instances share the stimulus:
// defaults, K = 1, and HOLD_MODE = 1. Inputs change and outputs are sampled
// just after the falling edge. A "tick" is one high clk followed by three low.
module tb_threat_countdown;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       arm;
  logic [2:0] threat;

  logic [3:0] cnt0, leds0, cnt1, leds1, cnt2, leds2;
  logic       fir0, fir1, fir2;
  logic [1:0] st0, st1, st2;

  int n_cmp;
  int n_bad;

  threat_countdown dut_def (
    .clk(clk), .rst(rst), .tick_i(tick), .arm_i(arm), .threat_i(threat),
    .count_o(cnt0), .fired_o(fir0), .leds_o(leds0), .state_o(st0)
  );

  threat_countdown #(.K(1)) dut_k1 (
    .clk(clk), .rst(rst), .tick_i(tick), .arm_i(arm), .threat_i(threat),
    .count_o(cnt1), .fired_o(fir1), .leds_o(leds1), .state_o(st1)
  );

  threat_countdown #(.HOLD_MODE(1)) dut_hold (
    .clk(clk), .rst(rst), .tick_i(tick), .arm_i(arm), .threat_i(threat),
    .count_o(cnt2), .fired_o(fir2), .leds_o(leds2), .state_o(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick = 1'b0; arm = 1'b0; threat = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; arm = 1'b0; threat = 3'b000;
    @(negedge clk);
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    n_cmp++; if (fir0 !== 1'b0) begin n_bad++; $display("FAIL reset_fired: got %0b want 0", fir0); end
    n_cmp++; if (leds0 !== 4'd0) begin n_bad++; $display("FAIL reset_leds: got %0h want 0", leds0); end
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st0); end
    rst = 1'b0;
  endtask

  task automatic test_countdown();
    apply_reset();
    arm = 1'b1; threat = 3'b011;
    run_ticks(2);
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL cd_idle_before_deb: got %0d want 0", st0); end
    // Third tick flips the debounced values; FSM follows one clk at a time.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL cd_idle_at_deb: got %0d want 0", st0); end
    @(negedge clk);
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL cd_armed: got %0d want 1", st0); end
    @(negedge clk);
    n_cmp++; if (st0 !== 2'd2) begin n_bad++; $display("FAIL cd_counting: got %0d want 2", st0); end
    @(negedge clk);
    run_ticks(99);
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL cd_count_99: got %0d want 0", cnt0); end
    run_ticks(1);
    n_cmp++; if (cnt0 !== 4'd1) begin n_bad++; $display("FAIL cd_count_100: got %0d want 1", cnt0); end
    run_ticks(899);
    n_cmp++; if (cnt0 !== 4'd9) begin n_bad++; $display("FAIL cd_count_999: got %0d want 9", cnt0); end
    n_cmp++; if (fir0 !== 1'b0) begin n_bad++; $display("FAIL cd_fired_999: got %0b want 0", fir0); end
    // 1000th counted tick: fired/count/state on this edge, leds one clk later.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_cmp++; if (fir0 !== 1'b1) begin n_bad++; $display("FAIL cd_fired_1000: got %0b want 1", fir0); end
    n_cmp++; if (cnt0 !== 4'd10) begin n_bad++; $display("FAIL cd_count_1000: got %0d want 10", cnt0); end
    n_cmp++; if (st0 !== 2'd3) begin n_bad++; $display("FAIL cd_state_fired: got %0d want 3", st0); end
    n_cmp++; if (leds0 !== 4'd9) begin n_bad++; $display("FAIL cd_leds_lag: got %0h want 9", leds0); end
    @(negedge clk);
    n_cmp++; if (leds0 !== 4'hf) begin n_bad++; $display("FAIL cd_leds_ones: got %0h want f", leds0); end
    repeat (2) @(negedge clk);
    run_ticks(500);
    n_cmp++; if (cnt0 !== 4'd10) begin n_bad++; $display("FAIL cd_count_frozen: got %0d want 10", cnt0); end
    n_cmp++; if (st0 !== 2'd3) begin n_bad++; $display("FAIL cd_state_frozen: got %0d want 3", st0); end
    n_cmp++; if (fir2 !== 1'b1) begin n_bad++; $display("FAIL cd_hold_fired: got %0b want 1", fir2); end
  endtask

  task automatic test_glitch();
    apply_reset();
    arm = 1'b1;
    run_ticks(3);
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL gl_armed: got %0d want 1", st0); end
    threat = 3'b011;
    run_ticks(2);
    threat = 3'b000;
    run_ticks(5);
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL gl_state: got %0d want 1", st0); end
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL gl_count: got %0d want 0", cnt0); end
    n_cmp++; if (st1 !== 2'd1) begin n_bad++; $display("FAIL gl_k1_state: got %0d want 1", st1); end
  endtask

  task automatic test_single_threat();
    apply_reset();
    arm = 1'b1; threat = 3'b100;
    // Ticks 1-3 debounce; counted ticks start at tick 4, so 1000th is tick 1003.
    run_ticks(1002);
    n_cmp++; if (cnt1 !== 4'd9) begin n_bad++; $display("FAIL st_k1_count_999: got %0d want 9", cnt1); end
    n_cmp++; if (fir1 !== 1'b0) begin n_bad++; $display("FAIL st_k1_fired_999: got %0b want 0", fir1); end
    run_ticks(1);
    n_cmp++; if (fir1 !== 1'b1) begin n_bad++; $display("FAIL st_k1_fired: got %0b want 1", fir1); end
    n_cmp++; if (cnt1 !== 4'd10) begin n_bad++; $display("FAIL st_k1_count: got %0d want 10", cnt1); end
    run_ticks(997);
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL st_k2_count: got %0d want 0", cnt0); end
    n_cmp++; if (fir0 !== 1'b0) begin n_bad++; $display("FAIL st_k2_fired: got %0b want 0", fir0); end
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL st_k2_state: got %0d want 1", st0); end
  endtask

  task automatic test_vote_drop();
    apply_reset();
    arm = 1'b1; threat = 3'b011;
    run_ticks(3);
    run_ticks(500);
    n_cmp++; if (cnt0 !== 4'd5) begin n_bad++; $display("FAIL vd_count5: got %0d want 5", cnt0); end
    n_cmp++; if (cnt2 !== 4'd5) begin n_bad++; $display("FAIL vd_hold_count5: got %0d want 5", cnt2); end
    // Counting continues through the 3 debounce ticks: sub reaches 3 before the drop.
    threat = 3'b001;
    run_ticks(3);
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL vd_state: got %0d want 1", st0); end
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL vd_count_clear: got %0d want 0", cnt0); end
    n_cmp++; if (st2 !== 2'd1) begin n_bad++; $display("FAIL vd_hold_state: got %0d want 1", st2); end
    n_cmp++; if (cnt2 !== 4'd5) begin n_bad++; $display("FAIL vd_hold_count: got %0d want 5", cnt2); end
    threat = 3'b011;
    run_ticks(3);
    // Held instance resumes at count 5, sub 3: 497 more ticks reach LIMIT.
    run_ticks(496);
    n_cmp++; if (fir2 !== 1'b0) begin n_bad++; $display("FAIL vd_hold_fired_early: got %0b want 0", fir2); end
    n_cmp++; if (cnt2 !== 4'd9) begin n_bad++; $display("FAIL vd_hold_count9: got %0d want 9", cnt2); end
    run_ticks(1);
    n_cmp++; if (fir2 !== 1'b1) begin n_bad++; $display("FAIL vd_hold_fired: got %0b want 1", fir2); end
    n_cmp++; if (cnt2 !== 4'd10) begin n_bad++; $display("FAIL vd_hold_count10: got %0d want 10", cnt2); end
    n_cmp++; if (cnt0 !== 4'd4) begin n_bad++; $display("FAIL vd_restart_count: got %0d want 4", cnt0); end
  endtask

  task automatic test_abort();
    apply_reset();
    arm = 1'b1; threat = 3'b011;
    run_ticks(703);
    n_cmp++; if (cnt0 !== 4'd7) begin n_bad++; $display("FAIL ab_count7: got %0d want 7", cnt0); end
    arm = 1'b0;
    run_ticks(3);
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL ab_state: got %0d want 0", st0); end
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL ab_count: got %0d want 0", cnt0); end
    n_cmp++; if (cnt2 !== 4'd0) begin n_bad++; $display("FAIL ab_hold_count: got %0d want 0", cnt2); end
  endtask

  task automatic test_fired_abort();
    apply_reset();
    arm = 1'b1; threat = 3'b011;
    run_ticks(1003);
    n_cmp++; if (fir0 !== 1'b1) begin n_bad++; $display("FAIL fa_fired: got %0b want 1", fir0); end
    arm = 1'b0;
    run_ticks(3);
    n_cmp++; if (fir0 !== 1'b0) begin n_bad++; $display("FAIL fa_fired_clear: got %0b want 0", fir0); end
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL fa_state: got %0d want 0", st0); end
    n_cmp++; if (leds0 !== 4'd0) begin n_bad++; $display("FAIL fa_leds: got %0h want 0", leds0); end
  endtask

  task automatic test_reset_mid_count();
    apply_reset();
    arm = 1'b1; threat = 3'b011;
    run_ticks(303);
    n_cmp++; if (cnt0 !== 4'd3) begin n_bad++; $display("FAIL rm_count3: got %0d want 3", cnt0); end
    rst = 1'b1; tick = 1'b1;
    @(negedge clk);
    n_cmp++; if (cnt0 !== 4'd0) begin n_bad++; $display("FAIL rm_count: got %0d want 0", cnt0); end
    n_cmp++; if (fir0 !== 1'b0) begin n_bad++; $display("FAIL rm_fired: got %0b want 0", fir0); end
    n_cmp++; if (leds0 !== 4'd0) begin n_bad++; $display("FAIL rm_leds: got %0h want 0", leds0); end
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL rm_state: got %0d want 0", st0); end
    rst = 1'b0; tick = 1'b0;
    @(negedge clk);
    run_ticks(3);
    n_cmp++; if (st0 !== 2'd2) begin n_bad++; $display("FAIL rm_recount_state: got %0d want 2", st0); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; tick = 1'b0; arm = 1'b0; threat = 3'b000;
    test_reset();
    test_countdown();
    test_glitch();
    test_single_threat();
    test_vote_drop();
    test_abort();
    test_fired_abort();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
